dma_read_scheduler: RTL and testbench

DMA_READ_SCHEDULER -- requirements
Module: dma_read_scheduler
Interface
REQ-001 Parameter ADDR_WIDTH, 49, AXI4 byte-address width.
REQ-002 Parameter DATA_SIZE, 4, log2 of bytes per beat (128-bit beats).
REQ-003 Parameter CNT_WIDTH, 32, width of the transfer beat count.
REQ-004 Parameter MAX_BURST, 16, maximum beats per AR burst (1..256).
REQ-005 Parameter MAX_OUTSTANDING, 4, maximum bursts issued whose rlast has not yet been received.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 s_start  input  1  one-cycle start request.
REQ-009 s_addr  input  ADDR_WIDTH  transfer start byte address; the low DATA_SIZE bits are ignored and treated as zero.
REQ-010 s_beats  input  CNT_WIDTH  total beats to read.
REQ-011 busy  output  1  high from the accepted start until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 m_axi4_araddr  output  ADDR_WIDTH  burst start address.
REQ-014 m_axi4_arlen  output  8  burst length minus 1.
REQ-015 m_axi4_arsize  output  3  constant DATA_SIZE.
REQ-016 m_axi4_arburst  output  2  constant 2'b01 (INCR).
REQ-017 m_axi4_arvalid / m_axi4_arready  output / input  1 each  AR handshake.
REQ-018 m_axi4_rdata / m_axi4_rlast / m_axi4_rvalid  input  128 / 1 / 1  read data channel.
REQ-019 m_axi4_rready  output  1  equals m_ready combinationally.
REQ-020 m_data / m_valid / m_ready  output / output / input  128 / 1 / 1  output stream; m_data = rdata and m_valid = rvalid, both combinational pass-through.
Function
REQ-021 FSM states are IDLE, ISSUE, DRAIN, and DONE.
REQ-022 In IDLE, s_start latches the address and beat count and sets busy on the next cycle; if s_beats==0, the FSM goes directly to DONE.
REQ-023 s_start outside IDLE is ignored and does not change any state.
REQ-024 In ISSUE, burst beats = min(remaining, MAX_BURST, beats to the next 4 KB boundary); arlen = beats-1.
REQ-025 Once asserted, arvalid, araddr, and arlen are held stable until arready; arvalid is asserted only while outstanding < MAX_OUTSTANDING.
REQ-026 On AR handshake: address += beats<<DATA_SIZE, remaining -= beats, outstanding += 1; ISSUE -> DRAIN when remaining reaches 0.
REQ-027 The outstanding count decrements on each rvalid&&rready&&rlast; a simultaneous AR handshake and rlast leave it unchanged.
REQ-028 In DRAIN, when outstanding==0 the FSM goes to DONE; DONE pulses done for 1 cycle, clears busy in the same cycle, and returns to IDLE.
REQ-029 AR issue latency: arvalid is asserted 1 cycle after the accepted start, and the next burst's arvalid is asserted 1 cycle after each AR handshake (subject to the outstanding limit).
REQ-030 Address arithmetic wraps modulo 2^ADDR_WIDTH; the beat counter never underflows.
Reset
REQ-031 On reset: FSM=IDLE, busy=0, done=0, arvalid=0, araddr=0, arlen=0, and all counters=0.
REQ-032 Reset asserted mid-transfer aborts the transfer immediately; no done pulse is generated.
Structure
REQ-033 AXI burst constants (BURST_INCR, 4 KB boundary) and the FSM state enum reside in shared package dma_calc_pkg.
REQ-034 Burst-length computation is sub-module dma_burst_len_calc (combinational: address, remaining -> beats).
Verification
REQ-035 addr 0x1000, beats 32, slave always ready -> two bursts with arlen 15 at 0x1000 and 0x1100; done after the 2nd rlast.
REQ-036 addr 0x0FC0, beats 10 -> bursts with arlen 3 at 0x0FC0 and arlen 5 at 0x1000; no 4 KB crossing.
REQ-037 beats 0 -> no arvalid; done pulses exactly 2 cycles after s_start.
REQ-038 beats 128, slave with 50% R busy and rlast withheld -> arvalid stops after 4 outstanding bursts and resumes on each rlast.
REQ-039 Reset asserted during ISSUE with arvalid high -> arvalid=0, busy=0 next edge; a new start then runs cleanly.
REQ-040 Second s_start while busy -> ignored; exactly one done pulse, total beats delivered match the first request.

---
 rtl/dma_calc_pkg.sv | 16 +
 rtl/dma_read_scheduler_if.sv | 31 +++
 rtl/dma_burst_len_calc.sv | 29 ++
 rtl/dma_read_scheduler.sv | 151 +++++++++++++++
 tb/tb_dma_read_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_calc_pkg.sv
// Shared constants and FSM state type for the DMA read scheduler.
// Holds the AXI burst type encoding and the 4 KB boundary that bursts must not cross.
package dma_calc_pkg;

    localparam logic [1:0]  BURST_INCR     = 2'b01;
    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned BOUNDARY_BITS  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dma_read_scheduler_if.sv
// AXI4 read address/data channels plus the forwarded output stream.
// The master modport is the scheduler side; the slave modport is the memory/consumer side.
interface dma_read_scheduler_if #(
    parameter int ADDR_WIDTH = 49,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready, m_data, m_valid,
        input  arready, rdata, rlast, rvalid, m_ready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready, m_data, m_valid,
        output arready, rdata, rlast, rvalid, m_ready
    );

endinterface

// File: rtl/dma_burst_len_calc.sv
// Combinational burst sizing: the smallest of remaining beats, the burst cap,
// and the beats left before the next 4 KB boundary.
module dma_burst_len_calc
    import dma_calc_pkg::*;
#(
    parameter int DATA_SIZE = 4,
    parameter int CNT_WIDTH = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [BOUNDARY_BITS-1:0] addr_low,
    input  logic [CNT_WIDTH-1:0]     remaining,
    output logic [8:0]               beats
);

    logic [BOUNDARY_BITS:0] bound_bytes_s;
    logic [BOUNDARY_BITS:0] bound_beats_s;
    logic [CNT_WIDTH-1:0]   lim_s;

    // Three-way minimum; addr_low is already beat aligned so the shift is exact.
    always_comb begin
        bound_bytes_s = (BOUNDARY_BITS+1)'(BOUNDARY_BYTES) - {1'b0, addr_low};
        bound_beats_s = bound_bytes_s >> DATA_SIZE;
        lim_s         = CNT_WIDTH'(MAX_BURST);
        lim_s         = (CNT_WIDTH'(bound_beats_s) < lim_s) ? CNT_WIDTH'(bound_beats_s) : lim_s;
        lim_s         = (remaining < lim_s) ? remaining : lim_s;
        beats         = 9'(lim_s);
    end

endmodule

// File: rtl/dma_read_scheduler.sv
// Splits a beat-count read request into AXI4 INCR bursts, limits bursts in flight,
// and forwards read data straight to the output stream.
module dma_read_scheduler
    import dma_calc_pkg::*;
#(
    parameter int ADDR_WIDTH      = 49,
    parameter int DATA_SIZE       = 4,
    parameter int CNT_WIDTH       = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_start,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [CNT_WIDTH-1:0]  s_beats,
    output logic                  busy,
    output logic                  done,
    dma_read_scheduler_if.master  bus
);

    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << DATA_SIZE) - ADDR_WIDTH'(1));

    state_e                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [CNT_WIDTH-1:0]  rem_r;
    logic [OUT_WIDTH-1:0]  out_r;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic [7:0]            arlen_r;
    logic                  arvalid_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  ar_hs_s;
    logic                  rl_hs_s;
    logic [8:0]            issued_beats_s;
    logic [ADDR_WIDTH-1:0] nxt_addr_s;
    logic [CNT_WIDTH-1:0]  nxt_rem_s;
    logic [OUT_WIDTH-1:0]  nxt_out_s;
    logic [ADDR_WIDTH-1:0] calc_addr_s;
    logic [CNT_WIDTH-1:0]  calc_rem_s;
    logic [8:0]            calc_beats_s;
    logic [7:0]            burst_len_s;

    assign bus.araddr  = araddr_r;
    assign bus.arlen   = arlen_r;
    assign bus.arvalid = arvalid_r;
    assign bus.arsize  = 3'(DATA_SIZE);
    assign bus.arburst = BURST_INCR;
    assign bus.rready  = bus.m_ready;
    assign bus.m_data  = bus.rdata;
    assign bus.m_valid = bus.rvalid;
    assign busy        = busy_r;
    assign done        = done_r;

    // Post-handshake view of address, remaining and in-flight count, so the next
    // burst can be presented in the cycle right after the current one is accepted.
    always_comb begin
        ar_hs_s        = arvalid_r & bus.arready;
        rl_hs_s        = bus.rvalid & bus.m_ready & bus.rlast & (out_r != {OUT_WIDTH{1'b0}});
        issued_beats_s = 9'd1 + {1'b0, arlen_r};
        nxt_addr_s     = ar_hs_s ? addr_r + (ADDR_WIDTH'(issued_beats_s) << DATA_SIZE) : addr_r;
        nxt_rem_s      = ar_hs_s ? rem_r - CNT_WIDTH'(issued_beats_s) : rem_r;
        case ({ar_hs_s, rl_hs_s})
            2'b10:   nxt_out_s = out_r + OUT_WIDTH'(1);
            2'b01:   nxt_out_s = out_r - OUT_WIDTH'(1);
            default: nxt_out_s = out_r;
        endcase
        calc_addr_s = (state_r == ST_IDLE) ? (s_addr & ALIGN_MASK) : nxt_addr_s;
        calc_rem_s  = (state_r == ST_IDLE) ? s_beats : nxt_rem_s;
        burst_len_s = 8'(calc_beats_s - 9'd1);
    end

    dma_burst_len_calc #(
        .DATA_SIZE (DATA_SIZE),
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .addr_low  (calc_addr_s[BOUNDARY_BITS-1:0]),
        .remaining (calc_rem_s),
        .beats     (calc_beats_s)
    );

    // Control FSM: accepts a request, issues bursts, drains in-flight reads, pulses done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            rem_r     <= {CNT_WIDTH{1'b0}};
            out_r     <= {OUT_WIDTH{1'b0}};
            araddr_r  <= {ADDR_WIDTH{1'b0}};
            arlen_r   <= 8'd0;
            arvalid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            out_r  <= nxt_out_s;
            case (state_r)
                ST_IDLE: begin
                    if (s_start) begin
                        addr_r <= calc_addr_s;
                        rem_r  <= s_beats;
                        busy_r <= 1'b1;
                        if (s_beats == {CNT_WIDTH{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r   <= ST_ISSUE;
                            arvalid_r <= 1'b1;
                            araddr_r  <= calc_addr_s;
                            arlen_r   <= burst_len_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    addr_r <= nxt_addr_s;
                    rem_r  <= nxt_rem_s;
                    if (nxt_rem_s == {CNT_WIDTH{1'b0}}) begin
                        arvalid_r <= 1'b0;
                        state_r   <= ST_DRAIN;
                    end else if (ar_hs_s || !arvalid_r) begin
                        // A pending request is never withdrawn; new ones wait for a free slot.
                        if (nxt_out_s < OUT_WIDTH'(MAX_OUTSTANDING)) begin
                            arvalid_r <= 1'b1;
                            araddr_r  <= calc_addr_s;
                            arlen_r   <= burst_len_s;
                        end else begin
                            arvalid_r <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_r == {OUT_WIDTH{1'b0}}) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Randomised scoreboard bench for dma_read_scheduler: a burst-plan model feeds expected
// AR requests and completions, a responder plays the AXI slave, a monitor compares.
module tb_dma_read_scheduler;

    localparam int AW = 49;
    localparam int DS = 4;
    localparam int CW = 32;
    localparam int MB = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_start = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [CW-1:0] s_beats = '0;
    logic          busy;
    logic          done;

    dma_read_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(128)) bus ();

    dma_read_scheduler #(
        .ADDR_WIDTH(AW), .DATA_SIZE(DS), .CNT_WIDTH(CW),
        .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .s_start(s_start), .s_addr(s_addr),
        .s_beats(s_beats), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;

    ar_t exp_ar[$];
    int  exp_done[$];
    int  rq[$];
    int  checks = 0;
    int  errors = 0;
    int  mon_out = 0;
    int  beats_seen = 0;
    int  ar_fires = 0;
    int  ap = 100;
    int  rp = 100;
    int  mp = 100;
    bit  r_hold = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference burst plan: split the request by cap and 4 KB room, address wraps mod 2^AW.
    task automatic plan(input logic [AW-1:0] addr, input int beats);
        logic [AW-1:0] a;
        int rem, room, b;
        a   = addr & ~(AW'(15));
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a % AW'(4096))) / 16;
            b = rem;
            if (b > MB) b = MB;
            if (b > room) b = room;
            exp_ar.push_back('{addr: a, len: 8'(b - 1)});
            a = a + AW'(b * 16);
            rem -= b;
        end
        exp_done.push_back(beats);
    endtask

    // AXI slave responder
    initial begin
        bit ar_fire, r_fire;
        int beat_idx, cap_len;
        ar_fire = 1'b0; r_fire = 1'b0; beat_idx = 0; cap_len = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
        bus.rdata = '0; bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rq.delete();
                beat_idx = 0; ar_fire = 1'b0; r_fire = 1'b0;
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.m_ready = 1'b0;
                continue;
            end
            if (ar_fire) rq.push_back(cap_len);
            if (r_fire && rq.size() > 0) begin
                if (beat_idx == rq[0]) begin
                    void'(rq.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            bus.arready = ($urandom_range(99) < ap);
            bus.m_ready = ($urandom_range(99) < mp);
            bus.rdata   = {$urandom, $urandom, $urandom, $urandom};
            if (rq.size() > 0 && !r_hold && $urandom_range(99) < rp) begin
                bus.rvalid = 1'b1;
                bus.rlast  = (beat_idx == rq[0]);
            end else begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
            end
            #1;
            ar_fire = bus.arvalid && bus.arready;
            cap_len = int'(bus.arlen);
            r_fire  = bus.rvalid && bus.m_ready;
        end
    end

    // Monitor / scoreboard
    initial begin
        ar_t e;
        logic [AW-1:0] prev_addr;
        logic [7:0]    prev_len;
        bit            prev_pend;
        prev_pend = 1'b0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_pend = 1'b0;
                continue;
            end
            if (bus.arvalid) begin
                chk("ar_outstanding_limit", 64'(mon_out < MO), 64'd1);
                if (prev_pend) begin
                    chk("araddr_stable", bus.araddr, prev_addr);
                    chk("arlen_stable", bus.arlen, prev_len);
                end
            end
            if (bus.m_valid || bus.rvalid) begin
                chk("m_valid_pass", bus.m_valid, bus.rvalid);
                chk("m_data_pass", 64'(bus.m_data == bus.rdata), 64'd1);
                chk("rready_pass", bus.rready, bus.m_ready);
            end
            if (bus.arvalid && bus.arready) begin
                ar_fires++;
                mon_out++;
                chk("arsize", bus.arsize, 64'd4);
                chk("arburst", bus.arburst, 64'd1);
                if (exp_ar.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ar actual=%0h/%0d required=none", bus.araddr, bus.arlen);
                end else begin
                    e = exp_ar.pop_front();
                    chk("araddr", bus.araddr, e.addr);
                    chk("arlen", bus.arlen, e.len);
                end
            end
            prev_pend = bus.arvalid && !bus.arready;
            prev_addr = bus.araddr;
            prev_len  = bus.arlen;
            if (bus.rvalid && bus.m_ready) begin
                beats_seen++;
                if (bus.rlast) mon_out--;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    chk("done_beats", beats_seen, exp_done.pop_front());
                    chk("done_ar_remaining", exp_ar.size(), 64'd0);
                    chk("done_outstanding", mon_out, 64'd0);
                    chk("done_busy_low", busy, 64'd0);
                end
                beats_seen = 0;
            end
        end
    end

    task automatic start(input logic [AW-1:0] addr, input int beats, input bit model_it);
        @(negedge clk);
        s_start = 1'b1;
        s_addr  = addr;
        s_beats = CW'(beats);
        if (model_it) plan(addr, beats);
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_done.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_done.size() > 0) begin
            checks++; errors++;
            $display("FAIL wait_done_timeout actual=pending required=complete");
            exp_done.delete();
            exp_ar.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [AW-1:0] ra;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 64'd0);
        chk("reset_done", done, 64'd0);
        chk("reset_arvalid", bus.arvalid, 64'd0);
        chk("reset_araddr", bus.araddr, 64'd0);
        chk("reset_arlen", bus.arlen, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two full bursts, first AR one cycle after start
        start(AW'(64'h1000), 32, 1'b1);
        #1;
        chk("first_arvalid_latency", bus.arvalid, 64'd1);
        chk("busy_after_start", busy, 64'd1);
        wait_done(500);

        // 4 KB boundary split, wrap at top of address space, unaligned start
        start(AW'(64'h0FC0), 10, 1'b1);
        wait_done(500);
        start(AW'(64'h1_FFFF_FFFF_FF00), 40, 1'b1);
        wait_done(500);
        start(AW'(64'h1238), 5, 1'b1);
        wait_done(500);

        // Zero-beat request: done exactly two cycles after start, no AR
        start(AW'(64'h2000), 0, 1'b1);
        #1;
        chk("zero_done_c1", done, 64'd0);
        chk("zero_busy_c1", busy, 64'd1);
        chk("zero_arvalid_c1", bus.arvalid, 64'd0);
        @(negedge clk); #1;
        chk("zero_done_c2", done, 64'd1);
        chk("zero_busy_c2", busy, 64'd0);
        chk("zero_arvalid_c2", bus.arvalid, 64'd0);
        @(negedge clk); #1;
        chk("zero_done_c3", done, 64'd0);
        wait_done(50);

        // Outstanding limit with R withheld, then slow R with back-pressure
        r_hold = 1'b1;
        base = ar_fires;
        start(AW'(64'h0), 128, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("outstanding_cap_bursts", ar_fires - base, 64'd4);
        chk("outstanding_cap_arvalid", bus.arvalid, 64'd0);
        r_hold = 1'b0; rp = 50; mp = 50;
        wait_done(3000);
        rp = 100; mp = 100;

        // Reset in ISSUE with arvalid pending
        ap = 0;
        start(AW'(64'h3000), 64, 1'b1);
        @(negedge clk); #1;
        chk("pre_reset_arvalid", bus.arvalid, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_arvalid", bus.arvalid, 64'd0);
        chk("abort_busy", busy, 64'd0);
        chk("abort_done", done, 64'd0);
        exp_ar.delete(); exp_done.delete();
        mon_out = 0; beats_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        ap = 100;
        start(AW'(64'h4000), 20, 1'b1);
        wait_done(500);

        // Second start while busy is ignored
        ap = 60; rp = 70;
        start(AW'(64'h5000), 48, 1'b1);
        repeat (3) @(negedge clk);
        start(AW'(64'h9000), 7, 1'b0);
        wait_done(2000);
        repeat (30) @(negedge clk);
        chk("ignored_start_no_ar", exp_ar.size(), 64'd0);

        // Randomised requests
        for (int i = 0; i < 12; i++) begin
            ap = int'($urandom_range(30, 100));
            rp = int'($urandom_range(30, 100));
            mp = int'($urandom_range(30, 100));
            ra = AW'({$urandom, $urandom});
            if (i % 2 == 0) ra[11:8] = 4'hF;
            start(ra, int'($urandom_range(0, 70)), 1'b1);
            wait_done(3000);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
